// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to a synchronous
// IMEM and buffers returned instructions in a small circular queue that feeds
// decode over a valid/ready handshake. A redirect flushes everything in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC_o,
    output logic        req_o,
    input  logic [31:0] ins_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_D,
    input  logic        ready_D,
    output logic [31:0] instr_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [31:0]   pc_inflight_q, pc_inflight_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [AW+1:0] occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    // Target low bits are dropped when the PC is reloaded.
    logic          unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Credit check counts queued entries plus the outstanding fetch; a pop in
    // the same cycle is deliberately not credited.
    assign occupancy = {1'b0, count_q} + {{(AW + 1){1'b0}}, inflight_q};
    assign issue     = !rst && !redirect_i && (occupancy < (AW + 2)'(DEPTH));

    // A redirect discards the response arriving in the same cycle.
    assign push      = inflight_q && !redirect_i;
    assign valid_D   = (count_q != '0) && !redirect_i;
    assign pop       = valid_D && ready_D;

    assign PC_o       = pc_q;
    assign req_o      = issue;
    assign pc_plus4_D = pc_D + 32'd4;

    // Head of queue toward decode; NOP at PC 0 when empty.
    always_comb begin
        instr_D = NOP;
        pc_D    = 32'h0;
        if (count_q != '0) begin
            instr_D = instr_mem[rd_ptr_q];
            pc_D    = pc_mem[rd_ptr_q];
        end
    end

    // Next-state for PC, in-flight tracking and queue pointers.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        pc_inflight_d = pc_inflight_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect_i) begin
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                pc_inflight_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            pc_inflight_q <= 32'h0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            pc_inflight_q <= pc_inflight_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; the count guards reads, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= ins_i;
            pc_mem[wr_ptr_q]    <= pc_inflight_q;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined RISC-V core. It owns the program counter, issues word fetches to a synchronous instruction memory, and buffers the returned instructions in a small queue. The queue feeds the decode stage over a valid/ready handshake. A redirect from execute (taken branch or jump) flushes everything in flight.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- DEPTH, 4: instruction queue entries. Power of two, at least 2.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- PC_o  out  32: fetch address to IMEM. Always word-aligned.
- req_o  out  1: fetch request; `PC_o` is valid this cycle.
- ins_i  in  32: IMEM read data, valid the cycle after an accepted `req_o`.
- redirect_i  in  1: execute-stage redirect strobe.
- redirect_pc_i  in  32: redirect target.
- valid_D  out  1: queue head valid toward decode.
- ready_D  in  1: decode accepts the head this cycle.
- instr_D  out  32: head instruction.
- pc_D  out  32: PC of the head instruction.
- pc_plus4_D  out  32: `pc_D + 4`, modulo 2^32.

## Operation
- State:
  - PC register.
  - In-flight flag `inflight` plus its PC `pc_inflight`.
  - Circular queue of {instr, pc} with read/write pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- Issue: `req_o = !rst && !redirect_i && (count + inflight < DEPTH)`.
  - The credit check ignores a same-cycle pop.
  - On issue: `PC <= PC + 4` (wraps modulo 2^32), `inflight <= 1`, `pc_inflight <= PC`. Otherwise `inflight <= 0`.
- Response: while `inflight` is 1, `{ins_i, pc_inflight}` is written at the write pointer. The credit rule guarantees the queue is never full at this point.
- Pop: when `valid_D && ready_D`, the read pointer advances.
- Push and pop in the same cycle leave count unchanged. Pointers wrap at DEPTH.
- `valid_D = (count != 0) && !redirect_i`.
- `instr_D` and `pc_D` come from the head entry. When count == 0, `instr_D` = 32'h0000_0013 (NOP) and `pc_D` = 0.
- Redirect (`redirect_i` = 1), which has priority over everything else:
  - `PC <= {redirect_pc_i[31:2], 2'b00}`.
  - Count and both pointers clear.
  - `inflight` clears, so the response arriving this cycle is discarded.
  - No pop is performed, and `req_o` is 0.
- Redirect held for several cycles: each cycle reloads PC and keeps the queue empty.

## Timing
- Reset values:
  - `PC_o` = RESET_PC, `req_o` = 0, `valid_D` = 0.
  - `instr_D` = 32'h0000_0013, `pc_D` = 0, `pc_plus4_D` = 4.
  - Queue empty, `inflight` = 0.
- Reset asserted mid-operation clears all state immediately (asynchronously). Any IMEM response in flight is ignored.
- Latency, issue to decode: `req_o` in cycle N → `ins_i` in N+1 → `valid_D` = 1 in N+2.
- First request: the first cycle after `rst` deasserts.
- Throughput: with `ready_D` held high, one instruction per cycle in steady state (count = 1, inflight = 1).
- Redirect in cycle R:
  - `PC_o` = target and `req_o` = 1 in R+1.
  - Target instruction reaches `valid_D` in R+3.
  - No instruction fetched before R reaches decode after R.
- Backpressure: with `ready_D` = 0, `req_o` drops once count + inflight = DEPTH. Exactly DEPTH instructions are held, none lost.
- `valid_D`, `instr_D` and `pc_D` are stable while `valid_D && !ready_D` and no redirect occurs.
- Redirect and IMEM response in the same cycle: the response is dropped.
- Redirect and `ready_D` in the same cycle: no handshake occurs, because `valid_D` is 0.

## Test plan
- Reset release: RESET_PC = 0, `ready_D` = 1, IMEM returns word = address.
  - `req_o` rises with `PC_o` = 0, 4, 8, …
  - `valid_D` rises 2 cycles after the first request, with `pc_D` = 0, `instr_D` = 0, then one instruction per cycle, `pc_plus4_D` = `pc_D + 4`.
- Backpressure: stream, then hold `ready_D` = 0 for 10 cycles.
  - `req_o` stops after the queue plus in-flight entry reach 4.
  - Head stays stable.
  - Releasing `ready_D` yields PCs contiguous with no gap or duplicate.
- Redirect mid-stream: redirect to 0x100 while the queue holds 3 entries and one fetch is in flight.
  - `valid_D` = 0 in the redirect cycle.
  - `PC_o` = 0x100 the next cycle.
  - The next `pc_D` seen by decode is 0x100, two cycles later.
- Misaligned and back-to-back redirect: redirect to 0x203, then to 0x400 the following cycle.
  - Only 0x400 is fetched and delivered.
  - 0x200 never appears on `valid_D`.
- PC wrap: RESET_PC = 32'hFFFF_FFF8.
  - Fetched PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - `pc_plus4_D` for FFFF_FFFC is 0.
- Reset mid-operation: assert `rst` asynchronously between edges with a full queue.
  - Outputs immediately take their reset values.
  - After release, fetching restarts at RESET_PC.
